// File: rtl/mc_main_control.sv
// Multi-cycle main control FSM for the MIPS core: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and enable, trapping on overflow or an undefined instruction.
module mc_main_control #(
    parameter bit OVF_TRAP = 1'b1,
    parameter int ALU_CW   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [5:0]        OPCODE,
    input  logic [5:0]        FUNCT,
    input  logic              ZF_OUT,
    input  logic              OF_OUT,
    output logic              PC_WRITE,
    output logic [1:0]        PC_SRC,
    output logic              IR_WRITE,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic              I_OR_D,
    output logic              EPC_WRITE,
    output logic              REG_WS,
    output logic [1:0]        Reg_Dest,
    output logic [2:0]        MEMtoREG,
    output logic [2:0]        REG_DATA_SEL,
    output logic              ALU_SEL1,
    output logic [2:0]        ALU_SEL2,
    output logic              SIGNEXT_SEL,
    output logic [ALU_CW-1:0] ALU_CONTROL,
    output logic              CAUSE_SEL,
    output logic              CAUSE_EN
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_R_EXEC, S_I_EXEC, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_EXCEPT
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000, OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LB    = 6'b100000, OP_LH   = 6'b100001, OP_LW   = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100, OP_LHU  = 6'b100101, OP_SW   = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000, FN_SRL  = 6'b000010, FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_ADDU = 6'b100001, FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011, FN_AND = 6'b100100, FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110, FN_NOR  = 6'b100111, FN_SLT  = 6'b101010;

    localparam logic [ALU_CW-1:0] ALU_AND = ALU_CW'(4'b0000);
    localparam logic [ALU_CW-1:0] ALU_OR  = ALU_CW'(4'b0001);
    localparam logic [ALU_CW-1:0] ALU_ADD = ALU_CW'(4'b0010);
    localparam logic [ALU_CW-1:0] ALU_XOR = ALU_CW'(4'b0011);
    localparam logic [ALU_CW-1:0] ALU_SUB = ALU_CW'(4'b0110);
    localparam logic [ALU_CW-1:0] ALU_SLT = ALU_CW'(4'b0111);
    localparam logic [ALU_CW-1:0] ALU_SLL = ALU_CW'(4'b1000);
    localparam logic [ALU_CW-1:0] ALU_SRL = ALU_CW'(4'b1001);
    localparam logic [ALU_CW-1:0] ALU_NOR = ALU_CW'(4'b1100);

    state_e state_q, state_d;
    logic   cause_q, cause_d;
    logic   r_known;
    logic   r_ovf_trap;
    logic   i_ovf_trap;
    logic   [ALU_CW-1:0] r_alu_op;
    logic   [ALU_CW-1:0] i_alu_op;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        r_known  = 1'b1;
        r_alu_op = ALU_ADD;
        unique case (FUNCT)
            FN_ADD, FN_ADDU: r_alu_op = ALU_ADD;
            FN_SUB, FN_SUBU: r_alu_op = ALU_SUB;
            FN_AND:          r_alu_op = ALU_AND;
            FN_OR:           r_alu_op = ALU_OR;
            FN_XOR:          r_alu_op = ALU_XOR;
            FN_NOR:          r_alu_op = ALU_NOR;
            FN_SLT:          r_alu_op = ALU_SLT;
            FN_SLL:          r_alu_op = ALU_SLL;
            FN_SRL:          r_alu_op = ALU_SRL;
            FN_JR:           r_alu_op = ALU_ADD;
            default:         r_known  = 1'b0;
        endcase

        unique case (OPCODE)
            OP_ANDI: i_alu_op = ALU_AND;
            OP_ORI:  i_alu_op = ALU_OR;
            OP_XORI: i_alu_op = ALU_XOR;
            OP_SLTI: i_alu_op = ALU_SLT;
            default: i_alu_op = ALU_ADD;
        endcase

        // Only the signed forms trap; the unsigned variants always wrap.
        r_ovf_trap = OVF_TRAP && OF_OUT && (FUNCT == FN_ADD || FUNCT == FN_SUB);
        i_ovf_trap = OVF_TRAP && OF_OUT && (OPCODE == OP_ADDI);
    end

    always_comb begin
        // NOTE: every output and next-state gets a default first, so no path can infer a latch.
        state_d      = state_q;
        cause_d      = cause_q;
        PC_WRITE     = 1'b0;
        PC_SRC       = 2'd0;
        IR_WRITE     = 1'b0;
        MEM_READ     = 1'b0;
        MEM_WRITE    = 1'b0;
        I_OR_D       = 1'b0;
        EPC_WRITE    = 1'b0;
        REG_WS       = 1'b0;
        Reg_Dest     = 2'd0;
        MEMtoREG     = 3'd0;
        REG_DATA_SEL = 3'd0;
        ALU_SEL1     = 1'b0;
        ALU_SEL2     = 3'd0;
        SIGNEXT_SEL  = 1'b0;
        ALU_CONTROL  = '0;
        CAUSE_SEL    = 1'b0;
        CAUSE_EN     = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                MEM_READ    = 1'b1;
                IR_WRITE    = 1'b1;
                ALU_SEL2    = 3'd1;
                ALU_CONTROL = ALU_ADD;
                PC_WRITE    = 1'b1;
                state_d     = S_DECODE;
            end

            S_DECODE: begin
                // Branch target PC+(imm<<2) is computed speculatively into ALU_REG_OUT.
                ALU_SEL2    = 3'd3;
                ALU_CONTROL = ALU_ADD;
                unique case (OPCODE)
                    OP_J: begin
                        PC_WRITE = 1'b1;
                        PC_SRC   = 2'd2;
                        state_d  = S_FETCH;
                    end
                    OP_JAL: begin
                        PC_WRITE = 1'b1;
                        PC_SRC   = 2'd2;
                        REG_WS   = 1'b1;
                        Reg_Dest = 2'd2;
                        MEMtoREG = 3'd5;
                        state_d  = S_FETCH;
                    end
                    OP_RTYPE: begin
                        if (r_known) begin
                            state_d = S_R_EXEC;
                        end else begin
                            state_d = S_EXCEPT;
                            cause_d = 1'b0;
                        end
                    end
                    OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state_d = S_I_EXEC;
                    default: begin
                        state_d = S_EXCEPT;
                        cause_d = 1'b0;
                    end
                endcase
            end

            S_R_EXEC: begin
                ALU_SEL1 = 1'b1;
                state_d  = S_FETCH;
                if (FUNCT == FN_JR) begin
                    ALU_SEL2    = 3'd4;
                    ALU_CONTROL = ALU_ADD;
                    PC_WRITE    = 1'b1;
                end else begin
                    ALU_CONTROL = r_alu_op;
                    if (r_ovf_trap) begin
                        state_d = S_EXCEPT;
                        cause_d = 1'b1;
                    end else begin
                        REG_WS   = 1'b1;
                        Reg_Dest = 2'd1;
                    end
                end
            end

            S_I_EXEC: begin
                ALU_SEL1    = 1'b1;
                ALU_SEL2    = 3'd2;
                ALU_CONTROL = i_alu_op;
                SIGNEXT_SEL = (OPCODE == OP_ANDI) || (OPCODE == OP_ORI) || (OPCODE == OP_XORI);
                state_d     = S_FETCH;
                if (i_ovf_trap) begin
                    state_d = S_EXCEPT;
                    cause_d = 1'b1;
                end else begin
                    REG_WS = 1'b1;
                end
            end

            S_MEM_ADDR: begin
                ALU_SEL1    = 1'b1;
                ALU_SEL2    = 3'd2;
                ALU_CONTROL = ALU_ADD;
                state_d     = (OPCODE == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
                I_OR_D   = 1'b1;
                MEM_READ = 1'b1;
                state_d  = S_MEM_WB;
            end

            S_MEM_WB: begin
                REG_WS   = 1'b1;
                MEMtoREG = 3'd4;
                unique case (OPCODE)
                    OP_LBU:  REG_DATA_SEL = 3'd1;
                    OP_LB:   REG_DATA_SEL = 3'd2;
                    OP_LHU:  REG_DATA_SEL = 3'd3;
                    OP_LH:   REG_DATA_SEL = 3'd4;
                    default: REG_DATA_SEL = 3'd0;
                endcase
                state_d = S_FETCH;
            end

            S_MEM_WR: begin
                I_OR_D    = 1'b1;
                MEM_WRITE = 1'b1;
                state_d   = S_FETCH;
            end

            S_BRANCH: begin
                ALU_SEL1    = 1'b1;
                ALU_CONTROL = ALU_SUB;
                PC_WRITE    = (OPCODE == OP_BNE) ? !ZF_OUT : ZF_OUT;
                PC_SRC      = 2'd1;
                state_d     = S_FETCH;
            end

            S_EXCEPT: begin
                // PC already advanced by 4 in FETCH, so EPC gets PC-4 = faulting instruction.
                CAUSE_EN    = 1'b1;
                CAUSE_SEL   = cause_q;
                EPC_WRITE   = 1'b1;
                ALU_SEL2    = 3'd1;
                ALU_CONTROL = ALU_SUB;
                PC_WRITE    = 1'b1;
                PC_SRC      = 2'd3;
                state_d     = S_FETCH;
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mc_main_control.sv
// Randomized self-checking bench for mc_main_control: a per-instruction reference model
// builds the expected control word for every cycle and each cycle is compared against it.
module tb_mc_main_control;

    localparam bit OVF_TRAP = 1'b1;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       epc_write;
        logic       reg_ws;
        logic [1:0] reg_dest;
        logic [2:0] mem_to_reg;
        logic [2:0] reg_data_sel;
        logic       alu_sel1;
        logic [2:0] alu_sel2;
        logic       signext_sel;
        logic [3:0] alu_control;
        logic       cause_sel;
        logic       cause_en;
    } ctl_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zf;
    logic       of;

    logic       pc_write, ir_write, mem_read, mem_write, i_or_d, epc_write, reg_ws;
    logic       alu_sel1, signext_sel, cause_sel, cause_en;
    logic [1:0] pc_src, reg_dest;
    logic [2:0] mem_to_reg, reg_data_sel, alu_sel2;
    logic [3:0] alu_control;
    ctl_t       obs;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] r_ops    [logic [5:0]];
    logic [3:0] i_ops    [logic [5:0]];
    logic [2:0] load_sel [logic [5:0]];
    ctl_t       exp_q    [$];

    mc_main_control #(.OVF_TRAP(OVF_TRAP), .ALU_CW(4)) dut (
        .CLK(clk), .RST(rst_n), .OPCODE(opcode), .FUNCT(funct), .ZF_OUT(zf), .OF_OUT(of),
        .PC_WRITE(pc_write), .PC_SRC(pc_src), .IR_WRITE(ir_write), .MEM_READ(mem_read),
        .MEM_WRITE(mem_write), .I_OR_D(i_or_d), .EPC_WRITE(epc_write), .REG_WS(reg_ws),
        .Reg_Dest(reg_dest), .MEMtoREG(mem_to_reg), .REG_DATA_SEL(reg_data_sel),
        .ALU_SEL1(alu_sel1), .ALU_SEL2(alu_sel2), .SIGNEXT_SEL(signext_sel),
        .ALU_CONTROL(alu_control), .CAUSE_SEL(cause_sel), .CAUSE_EN(cause_en)
    );

    assign obs = ctl_t'({pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d, epc_write,
                         reg_ws, reg_dest, mem_to_reg, reg_data_sel, alu_sel1, alu_sel2,
                         signext_sel, alu_control, cause_sel, cause_en});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input ctl_t got, input ctl_t want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %07h want %07h", tag, got, want);
        end
    endtask

    // Reference: the instruction's cycle-by-cycle control words, derived from its class.
    task automatic build_plan(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic o);
        ctl_t v;
        logic trap, bad;
        exp_q.delete();
        trap = 1'b0;
        bad  = 1'b0;

        v = '0;
        v.mem_read = 1'b1; v.ir_write = 1'b1; v.pc_write = 1'b1;
        v.alu_sel2 = 3'd1; v.alu_control = 4'b0010;
        exp_q.push_back(v);

        v = '0;
        v.alu_sel2 = 3'd3; v.alu_control = 4'b0010;
        if (op == 6'b000010 || op == 6'b000011) begin
            v.pc_write = 1'b1; v.pc_src = 2'd2;
            if (op == 6'b000011) begin
                v.reg_ws = 1'b1; v.reg_dest = 2'd2; v.mem_to_reg = 3'd5;
            end
            exp_q.push_back(v);
            return;
        end
        exp_q.push_back(v);

        v = '0;
        if (op == 6'b000000) begin
            if (fn == 6'b001000) begin
                v.alu_sel1 = 1'b1; v.alu_sel2 = 3'd4; v.alu_control = 4'b0010; v.pc_write = 1'b1;
                exp_q.push_back(v);
            end else if (r_ops.exists(fn)) begin
                v.alu_sel1 = 1'b1; v.alu_control = r_ops[fn];
                trap = OVF_TRAP && o && (fn == 6'b100000 || fn == 6'b100010);
                if (!trap) begin
                    v.reg_ws = 1'b1; v.reg_dest = 2'd1;
                end
                exp_q.push_back(v);
            end else begin
                bad = 1'b1;
            end
        end else if (i_ops.exists(op)) begin
            v.alu_sel1 = 1'b1; v.alu_sel2 = 3'd2; v.alu_control = i_ops[op];
            v.signext_sel = (op == 6'b001100 || op == 6'b001101 || op == 6'b001110);
            trap = OVF_TRAP && o && (op == 6'b001000);
            v.reg_ws = !trap;
            exp_q.push_back(v);
        end else if (load_sel.exists(op) || op == 6'b101011) begin
            v.alu_sel1 = 1'b1; v.alu_sel2 = 3'd2; v.alu_control = 4'b0010;
            exp_q.push_back(v);
            v = '0;
            v.i_or_d = 1'b1;
            if (op == 6'b101011) begin
                v.mem_write = 1'b1;
                exp_q.push_back(v);
            end else begin
                v.mem_read = 1'b1;
                exp_q.push_back(v);
                v = '0;
                v.reg_ws = 1'b1; v.mem_to_reg = 3'd4; v.reg_data_sel = load_sel[op];
                exp_q.push_back(v);
            end
        end else if (op == 6'b000100 || op == 6'b000101) begin
            v.alu_sel1 = 1'b1; v.alu_control = 4'b0110; v.pc_src = 2'd1;
            v.pc_write = (op == 6'b000100) ? z : !z;
            exp_q.push_back(v);
        end else begin
            bad = 1'b1;
        end

        if (trap || bad) begin
            v = '0;
            v.cause_en = 1'b1; v.cause_sel = trap; v.epc_write = 1'b1;
            v.alu_sel2 = 3'd1; v.alu_control = 4'b0110; v.pc_write = 1'b1; v.pc_src = 2'd3;
            exp_q.push_back(v);
        end
    endtask

    // Runs one instruction from FETCH; abort_at >= 0 pulls reset during that cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input logic o, input int abort_at);
        build_plan(op, fn, z, o);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                opcode = op; funct = fn; zf = z; of = o;
            end
            #1;
            check($sformatf("op%02h_fn%02h_z%0d_o%0d_c%0d", op, fn, z, o, i), obs, exp_q[i]);
            if (i == abort_at) begin
                #1 rst_n = 1'b0;
                #1 check($sformatf("abort_op%02h_c%0d", op, i), obs, ctl_t'('0));
                @(posedge clk);
                #2 check("held_in_reset", obs, ctl_t'('0));
                #1 rst_n = 1'b1;
                #1 check("idle_after_abort", obs, ctl_t'('0));
                return;
            end
        end
    endtask

    localparam logic [5:0] VALID_OPS [17] = '{
        6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2B};
    localparam logic [5:0] VALID_FNS [12] = '{
        6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};

    initial begin
        logic [5:0] op, fn;

        r_ops[6'h20] = 4'b0010; r_ops[6'h21] = 4'b0010;
        r_ops[6'h22] = 4'b0110; r_ops[6'h23] = 4'b0110;
        r_ops[6'h24] = 4'b0000; r_ops[6'h25] = 4'b0001;
        r_ops[6'h26] = 4'b0011; r_ops[6'h27] = 4'b1100;
        r_ops[6'h2A] = 4'b0111; r_ops[6'h00] = 4'b1000; r_ops[6'h02] = 4'b1001;
        i_ops[6'h08] = 4'b0010; i_ops[6'h09] = 4'b0010; i_ops[6'h0A] = 4'b0111;
        i_ops[6'h0C] = 4'b0000; i_ops[6'h0D] = 4'b0001; i_ops[6'h0E] = 4'b0011;
        load_sel[6'h23] = 3'd0; load_sel[6'h24] = 3'd1; load_sel[6'h20] = 3'd2;
        load_sel[6'h25] = 3'd3; load_sel[6'h21] = 3'd4;

        rst_n = 1'b0; opcode = '0; funct = '0; zf = 1'b0; of = 1'b0;
        #2 check("in_reset", obs, ctl_t'('0));
        #10 rst_n = 1'b1;
        #1 check("idle_after_release", obs, ctl_t'('0));

        run_instr(6'h00, 6'h20, 1'b0, 1'b0, -1);  // add, no overflow
        run_instr(6'h00, 6'h20, 1'b0, 1'b1, -1);  // add, overflow trap
        run_instr(6'h00, 6'h21, 1'b0, 1'b1, -1);  // addu never traps
        run_instr(6'h00, 6'h08, 1'b0, 1'b0, -1);  // jr
        run_instr(6'h00, 6'h3F, 1'b0, 1'b0, -1);  // undefined funct
        run_instr(6'h20, 6'h00, 1'b0, 1'b0, -1);  // lb
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0, -1);  // sw
        run_instr(6'h04, 6'h00, 1'b1, 1'b0, -1);  // beq taken
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, -1);  // beq not taken
        run_instr(6'h05, 6'h00, 1'b1, 1'b0, -1);  // bne not taken
        run_instr(6'h05, 6'h00, 1'b0, 1'b0, -1);  // bne taken
        run_instr(6'h03, 6'h00, 1'b0, 1'b0, -1);  // jal
        run_instr(6'h3F, 6'h00, 1'b0, 1'b0, -1);  // undefined opcode
        run_instr(6'h08, 6'h00, 1'b0, 1'b1, -1);  // addi overflow trap
        run_instr(6'h09, 6'h00, 1'b0, 1'b1, -1);  // addiu wraps
        run_instr(6'h0D, 6'h00, 1'b0, 1'b0, -1);  // ori zero-extends
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0, 3);   // reset during MEM_WR
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 2);   // reset during load address phase

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            else                           op = VALID_OPS[$urandom_range(0, 16)];
            if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
            else                           fn = VALID_FNS[$urandom_range(0, 11)];
            run_instr(op, fn, 1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0) ? 1 : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
